// File: rtl/game_pkg.sv
// Shared types and helpers for the scrolling-note game core.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } game_state_t;

  localparam int unsigned MAX_LANES = 8;
  localparam int unsigned CNT_W     = 4;

  // Number of set bits in a lane vector (up to MAX_LANES lanes).
  function automatic logic [CNT_W-1:0] popcount(input logic [MAX_LANES-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < int'(MAX_LANES); i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/note_lane.sv
// One note lane: a shift register scrolling from the spawn cell toward the hit cell (cell 0).
module note_lane #(
  parameter int unsigned LANE_LEN = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear_i,
  input  logic                tick_i,
  input  logic                spawn_i,
  input  logic                clear_hit_i,
  output logic [LANE_LEN-1:0] cells_o,
  output logic                cell0_o,
  output logic                escaped_c
);

  logic [LANE_LEN-1:0] cells_q;

  // A hit on a tick cycle needs no explicit clear: cell 0 shifts out anyway.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cells_q <= '0;
    end else if (clear_i) begin
      cells_q <= '0;
    end else if (tick_i) begin
      cells_q <= {spawn_i, cells_q[LANE_LEN-1:1]};
    end else if (clear_hit_i) begin
      cells_q[0] <= 1'b0;
    end
  end

  assign cells_o   = cells_q;
  assign cell0_o   = cells_q[0];
  assign escaped_c = tick_i & cells_q[0] & ~clear_hit_i;

endmodule

// File: rtl/note_lane_engine.sv
// Scrolling-note game core: lanes, tick divider, press scoring, miss limit and game FSM.
module note_lane_engine
  import game_pkg::*;
#(
  parameter int unsigned NUM_LANES  = 2,
  parameter int unsigned LANE_LEN   = 7,
  parameter int unsigned TICK_DIV   = 1_000_000,
  parameter int unsigned SCORE_W    = 8,
  parameter int unsigned MISS_LIMIT = 5,
  parameter int unsigned MISS_W     = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [NUM_LANES-1:0]          button,
  input  logic                          spawn_valid,
  input  logic [NUM_LANES-1:0]          spawn_lanes,
  output logic                          spawn_ready,
  output logic [NUM_LANES*LANE_LEN-1:0] lane_disp,
  output logic                          hit,
  output logic                          miss,
  output logic [SCORE_W-1:0]            score,
  output logic [MISS_W-1:0]             misses,
  output logic                          running,
  output logic                          game_over
);

  localparam int unsigned TICK_W = $clog2(TICK_DIV);
  localparam int unsigned SUM_SW = ((SCORE_W > CNT_W) ? SCORE_W : CNT_W) + 1;
  localparam int unsigned SUM_MW = ((MISS_W > CNT_W) ? MISS_W : CNT_W) + 1;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [MISS_W-1:0]  MISS_MAX  = MISS_W'(MISS_LIMIT);
  localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_DIV - 1);

  game_state_t          state_q;
  logic [TICK_W-1:0]    tick_cnt_q;
  logic [NUM_LANES-1:0] button_q;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [MISS_W-1:0]    misses_q, misses_d;
  logic                 hit_q, miss_q;

  logic                 run, tick, scoring, clear_all;
  logic [NUM_LANES-1:0] press, cell0, escaped, hit_vec, wrong_vec, esc_vec;
  logic [CNT_W-1:0]     hit_cnt, miss_cnt;
  logic [SUM_SW-1:0]    score_sum;
  logic [SUM_MW-1:0]    miss_sum;

  assign run       = (state_q == RUN);
  assign tick      = run && (tick_cnt_q == TICK_LAST);
  assign scoring   = run && (misses_q < MISS_MAX);
  assign clear_all = (state_q != RUN) && start;
  assign press     = scoring ? (button & ~button_q) : '0;
  assign hit_vec   = press & cell0;
  assign wrong_vec = press & ~cell0;
  assign esc_vec   = scoring ? escaped : '0;

  for (genvar l = 0; l < int'(NUM_LANES); l++) begin : g_lane
    note_lane #(.LANE_LEN(LANE_LEN)) u_lane (
      .clk         (clk),
      .reset       (reset),
      .clear_i     (clear_all),
      .tick_i      (tick),
      .spawn_i     (spawn_valid & spawn_lanes[l]),
      .clear_hit_i (hit_vec[l]),
      .cells_o     (lane_disp[l*LANE_LEN +: LANE_LEN]),
      .cell0_o     (cell0[l]),
      .escaped_c   (escaped[l])
    );
  end

  // A lane cannot both take a wrong press and lose a note, so miss_cnt never exceeds NUM_LANES.
  always_comb begin
    hit_cnt   = popcount(MAX_LANES'(hit_vec));
    miss_cnt  = popcount(MAX_LANES'(wrong_vec)) + popcount(MAX_LANES'(esc_vec));
    score_sum = SUM_SW'(score_q) + SUM_SW'(hit_cnt);
    miss_sum  = SUM_MW'(misses_q) + SUM_MW'(miss_cnt);
    score_d   = (score_sum > SUM_SW'(SCORE_MAX)) ? SCORE_MAX : SCORE_W'(score_sum);
    misses_d  = (miss_sum >= SUM_MW'(MISS_MAX)) ? MISS_MAX : MISS_W'(miss_sum);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      button_q   <= '0;
      score_q    <= '0;
      misses_q   <= '0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
    end else begin
      button_q <= button;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      case (state_q)
        IDLE, OVER: begin
          if (start) begin
            state_q    <= RUN;
            tick_cnt_q <= '0;
            score_q    <= '0;
            misses_q   <= '0;
          end
        end
        RUN: begin
          tick_cnt_q <= tick ? '0 : tick_cnt_q + TICK_W'(1);
          if (misses_q == MISS_MAX) begin
            state_q <= OVER;
          end else begin
            score_q  <= score_d;
            misses_q <= misses_d;
            hit_q    <= (hit_cnt != '0);
            miss_q   <= (miss_cnt != '0);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign spawn_ready = tick;
  assign running     = run;
  assign game_over   = (state_q == OVER);
  assign score       = score_q;
  assign misses      = misses_q;
  assign hit         = hit_q;
  assign miss        = miss_q;

endmodule

// File: tb/tb_note_lane_engine.sv
// Randomized scoreboard bench for note_lane_engine against a cell-array game model.
module tb_note_lane_engine;

  localparam int unsigned NL = 2;
  localparam int unsigned LL = 7;
  localparam int unsigned TD = 4;
  localparam int unsigned SW = 3;
  localparam int unsigned ML = 3;
  localparam int unsigned MW = 4;
  localparam int SCORE_TOP = (1 << SW) - 1;

  typedef struct packed {
    logic [NL*LL-1:0] disp;
    logic             hit;
    logic             miss;
    logic [SW-1:0]    score;
    logic [MW-1:0]    misses;
    logic             running;
    logic             over;
    logic             ready;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [NL-1:0] button = '0;
  logic spawn_valid = 1'b0;
  logic [NL-1:0] spawn_lanes = '0;
  logic spawn_ready;
  logic [NL*LL-1:0] lane_disp;
  logic hit, miss;
  logic [SW-1:0] score;
  logic [MW-1:0] misses;
  logic running, game_over;

  always #5 clk = ~clk;

  note_lane_engine #(
    .NUM_LANES(NL), .LANE_LEN(LL), .TICK_DIV(TD),
    .SCORE_W(SW), .MISS_LIMIT(ML), .MISS_W(MW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .button(button),
    .spawn_valid(spawn_valid), .spawn_lanes(spawn_lanes), .spawn_ready(spawn_ready),
    .lane_disp(lane_disp), .hit(hit), .miss(miss), .score(score), .misses(misses),
    .running(running), .game_over(game_over)
  );

  // Game model: note grid plus score/miss bookkeeping, stepped once per clock.
  bit          m_run, m_over, m_hitp, m_missp;
  bit [LL-1:0] m_lane [NL];
  int          m_score, m_miss, m_cnt;
  bit [NL-1:0] m_prev;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 25) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_step(bit rst, bit st, bit [NL-1:0] btn, bit sv, bit [NL-1:0] sl);
    bit [NL-1:0] press;
    int hits, added;
    bit tk;
    m_hitp = 0;
    m_missp = 0;
    if (rst) begin
      m_run = 0; m_over = 0; m_score = 0; m_miss = 0; m_cnt = 0; m_prev = '0;
      for (int l = 0; l < NL; l++) m_lane[l] = '0;
      return;
    end
    press = btn & ~m_prev;
    m_prev = btn;
    if (!m_run) begin
      if (st) begin
        m_run = 1; m_over = 0; m_score = 0; m_miss = 0; m_cnt = 0;
        for (int l = 0; l < NL; l++) m_lane[l] = '0;
      end
    end else begin
      tk = (m_cnt == TD - 1);
      if (m_miss >= ML) begin
        m_run = 0;
        m_over = 1;
      end else begin
        hits = 0;
        added = 0;
        for (int l = 0; l < NL; l++) begin
          if (press[l]) begin
            if (m_lane[l][0]) begin hits++; m_lane[l][0] = 1'b0; end
            else added++;
          end
          if (tk && m_lane[l][0]) added++;
        end
        m_score = (m_score + hits > SCORE_TOP) ? SCORE_TOP : m_score + hits;
        m_miss  = (m_miss + added > ML) ? ML : m_miss + added;
        m_hitp  = (hits > 0);
        m_missp = (added > 0);
      end
      if (tk) for (int l = 0; l < NL; l++) m_lane[l] = {sv & sl[l], m_lane[l][LL-1:1]};
      m_cnt = tk ? 0 : m_cnt + 1;
    end
  endfunction

  function automatic exp_t model_expect();
    exp_t e;
    e.disp = '0;
    for (int l = 0; l < NL; l++)
      for (int c = 0; c < LL; c++) e.disp[l*LL + c] = m_lane[l][c];
    e.hit     = m_hitp;
    e.miss    = m_missp;
    e.score   = SW'(m_score);
    e.misses  = MW'(m_miss);
    e.running = m_run;
    e.over    = m_over;
    e.ready   = m_run && (m_cnt == TD - 1);
    return e;
  endfunction

  // Monitor: after each active edge, compare the DUT against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        check("lane_disp", 32'(lane_disp), 32'(e.disp));
        check("hit", 32'(hit), 32'(e.hit));
        check("miss", 32'(miss), 32'(e.miss));
        check("score", 32'(score), 32'(e.score));
        check("misses", 32'(misses), 32'(e.misses));
        check("running", 32'(running), 32'(e.running));
        check("game_over", 32'(game_over), 32'(e.over));
        check("spawn_ready", 32'(spawn_ready), 32'(e.ready));
      end
    end
  end

  initial begin
    int good_pct, err_pm;
    bit [NL-1:0] b;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      good_pct = (i < 2500) ? 65 : 30;
      err_pm   = (i < 2500) ? 2 : 20;
      reset = (i < 2) || (i == 900) || (i > 10 && $urandom_range(999) < 2);
      if (reset) begin
        b = '0;
      end else begin
        b = button;
        for (int l = 0; l < NL; l++) begin
          if (b[l]) b[l] = ($urandom_range(99) < 75);
          else if (m_run && m_lane[l][0]) b[l] = ($urandom_range(99) < good_pct);
          else b[l] = ($urandom_range(999) < err_pm);
        end
      end
      button      = b;
      start       = m_run ? bit'($urandom_range(1)) : ($urandom_range(99) < 12);
      spawn_valid = ($urandom_range(99) < 55);
      spawn_lanes = NL'($urandom);
      model_step(reset, start, button, spawn_valid, spawn_lanes);
      q.push_back(model_expect());
      if (reset) begin
        #1;
        check("async_rst_running", 32'(running), 32'd0);
        check("async_rst_score", 32'(score), 32'd0);
        check("async_rst_disp", 32'(lane_disp), 32'd0);
        check("async_rst_misses", 32'(misses), 32'd0);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    button = '0;
    start = 1'b0;
    @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
